// File: rtl/c3lib_gf_clksel_ctrl_if.sv
// ============================================================================
// c3lib_gf_clksel_ctrl_if : switch-request handshake and completion pulses
// Revision: 1.0
// ============================================================================
`default_nettype none

interface c3lib_gf_clksel_ctrl_if;
  logic i_req_vld;
  logic i_req_sel;
  logic o_req_rdy;
  logic o_done;
  logic o_err;

  modport slave (
    input  i_req_vld,
    input  i_req_sel,
    output o_req_rdy,
    output o_done,
    output o_err
  );

  modport master (
    output i_req_vld,
    output i_req_sel,
    input  o_req_rdy,
    input  o_done,
    input  o_err
  );
endinterface

`default_nettype wire

// File: rtl/c3lib_gf_clksel_ctrl.sv
// ============================================================================
// c3lib_gf_clksel_ctrl : clock-select sequencer for the glitch-free clock mux
// Revision: 1.0
// ============================================================================
`default_nettype none

module c3lib_gf_clksel_ctrl #(
  parameter int SETTLE_CYC = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  c3lib_gf_clksel_ctrl_if.slave      req_if,
  input  wire logic                  i_clk_a_ok,
  input  wire logic                  i_clk_b_ok,
  input  wire logic                  i_scan_mode_n,
  output logic                       o_sel_clk,
  output logic                       o_busy
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] C_CNT_LOAD = CNT_WIDTH'(SETTLE_CYC - 1);

  state_t                r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_nxt;
  logic                  r_sel, w_sel_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_err, w_err_nxt;
  logic                  r_a_meta, r_a_ok;
  logic                  r_b_meta, r_b_ok;
  logic                  w_accept;
  logic                  w_tgt_ok;

  // Two-flop synchronizers for the async clock-running levels, reset to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_meta <= 1'b0;
      r_a_ok   <= 1'b0;
      r_b_meta <= 1'b0;
      r_b_ok   <= 1'b0;
    end else begin
      r_a_meta <= i_clk_a_ok;
      r_a_ok   <= r_a_meta;
      r_b_meta <= i_clk_b_ok;
      r_b_ok   <= r_b_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sel   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign w_accept = req_if.i_req_vld && (r_state == ST_IDLE);
  assign w_tgt_ok = req_if.i_req_sel ? r_b_ok : r_a_ok;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (req_if.i_req_sel == r_sel) begin
            w_done_nxt = 1'b1;
          end else if (!w_tgt_ok) begin
            w_err_nxt = 1'b1;
          end else begin
            w_sel_nxt   = req_if.i_req_sel;
            w_state_nxt = ST_SETTLE;
            w_cnt_nxt   = C_CNT_LOAD;
            w_busy_nxt  = 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        // Requests are dropped here; a losing target clock does not abort.
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Scan forces the clock-A path after the register; the FSM keeps running.
  assign o_sel_clk        = r_sel & i_scan_mode_n;
  assign o_busy           = r_busy;
  assign req_if.o_req_rdy = (r_state == ST_IDLE);
  assign req_if.o_done    = r_done;
  assign req_if.o_err     = r_err;

endmodule

`default_nettype wire
